ef_uart_autobaud: RTL and testbench

Automatic baud-rate detector that sits directly upstream of the UART's prescaler register. It watches the raw `rx` line for a host-sent 0x55 sync character (8N1) and measures its bit time in clock cycles. It then produces the prescaler value `pr` that the UART needs, using the rule baud = f_clk / ((PR+1)·8). Firmware or glue logic writes `pr` into the UART's PR register when `pr_valid` pulses.

---
 rtl/ef_uart_autobaud_pkg.sv | 20 ++
 rtl/ef_uart_autobaud_sync.sv | 33 +++
 rtl/ef_uart_autobaud.sv | 181 ++++++++++++++++++
 tb/tb_ef_uart_autobaud.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ef_uart_autobaud_pkg.sv
// Shared types and constants for the UART auto-baud detector.
`timescale 1ns/1ps
package ef_uart_autobaud_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WAITSTART,
    MEASURE,
    STOPCHK,
    DONE,
    ERR
  } state_t;

  localparam int SYNC_FALL_EDGES = 5;
  localparam int PR_ROUND        = 32;
  localparam int PR_SHIFT        = 6;
  localparam int TOL_SHIFT       = 3;

endpackage

// File: rtl/ef_uart_autobaud_sync.sv
// Two-flop synchronizer for the raw rx line plus one history flop for edge detection.
`timescale 1ns/1ps
module ef_uart_autobaud_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  output logic level,
  output logic fall,
  output logic rise
);

  logic meta;
  logic sync;
  logic hist;

  // Reset to the idle-high level so no false edge appears after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= 1'b1;
      sync <= 1'b1;
      hist <= 1'b1;
    end else begin
      meta <= rx;
      sync <= meta;
      hist <= sync;
    end
  end

  assign level = sync;
  assign fall  = hist & ~sync;
  assign rise  = ~hist & sync;

endmodule

// File: rtl/ef_uart_autobaud.sv
// Measures a 0x55 sync character on rx and derives the UART prescaler
// pr = ((T8 + 32) >> 6) - 1, where T8 is eight bit times in clk cycles.
`timescale 1ns/1ps
module ef_uart_autobaud
  import ef_uart_autobaud_pkg::*;
#(
  parameter int CW     = 24,
  parameter int PR_W   = 16,
  parameter int MIN_T8 = 128
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            rx,
  output logic [PR_W-1:0] pr,
  output logic            pr_valid,
  output logic            locked,
  output logic            err,
  output logic            busy
);

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  logic level;
  logic fall;
  logic rise;

  ef_uart_autobaud_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .rx    (rx),
    .level (level),
    .fall  (fall),
    .rise  (rise)
  );

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    edges;
  logic [CW-1:0] last;
  logic [CW-1:0] i1;
  logic [CW-1:0] t8;
  logic          rise_seen;

  logic [CW-1:0] cnt_inc;
  logic [CW-1:0] interval;
  logic [CW-1:0] deviation;
  logic          off_tol;
  logic [CW:0]   pr_sum;
  logic [CW:0]   pr_quot;
  logic [CW:0]   pr_calc;
  logic          pr_ok;

  // cnt_inc is the elapsed cycle count since the start-bit falling edge.
  assign cnt_inc   = cnt + CW'(1);
  assign interval  = cnt_inc - last;
  assign deviation = (interval >= i1) ? (interval - i1) : (i1 - interval);
  assign off_tol   = deviation > (i1 >> TOL_SHIFT);

  assign pr_sum  = {1'b0, t8} + (CW+1)'(PR_ROUND);
  assign pr_quot = pr_sum >> PR_SHIFT;
  assign pr_calc = pr_quot - (CW+1)'(1);
  // Quotient of 0 or 1 would give a wrapped or zero prescaler.
  assign pr_ok   = (pr_quot > (CW+1)'(1)) && ((pr_calc >> PR_W) == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      edges     <= '0;
      last      <= '0;
      i1        <= '0;
      t8        <= '0;
      rise_seen <= 1'b0;
      pr        <= '0;
      pr_valid  <= 1'b0;
      locked    <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      pr_valid <= 1'b0;
      err      <= 1'b0;
      if (!en) begin
        state  <= IDLE;
        locked <= 1'b0;
        busy   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state  <= ARM;
            locked <= 1'b0;
          end
          ARM: begin
            if (level) state <= WAITSTART;
          end
          WAITSTART: begin
            if (fall) begin
              cnt   <= '0;
              edges <= 3'd1;
              last  <= '0;
              busy  <= 1'b1;
              state <= MEASURE;
            end
          end
          MEASURE: begin
            cnt <= cnt_inc;
            if (cnt == CNT_MAX) begin
              state <= ERR;
              err   <= 1'b1;
              busy  <= 1'b0;
            end else if (fall) begin
              edges <= edges + 3'd1;
              last  <= cnt_inc;
              if (edges == 3'd1) begin
                i1 <= interval;
              end else if (off_tol) begin
                state <= ERR;
                err   <= 1'b1;
                busy  <= 1'b0;
              end else if (edges == 3'(SYNC_FALL_EDGES - 1)) begin
                t8 <= cnt_inc;
                if (cnt_inc < CW'(MIN_T8)) begin
                  state <= ERR;
                  err   <= 1'b1;
                  busy  <= 1'b0;
                end else begin
                  cnt       <= '0;
                  rise_seen <= 1'b0;
                  state     <= STOPCHK;
                end
              end
            end
          end
          STOPCHK: begin
            cnt <= cnt_inc;
            if (cnt == CNT_MAX) begin
              state <= ERR;
              err   <= 1'b1;
              busy  <= 1'b0;
            end else if (!rise_seen) begin
              if (rise) begin
                rise_seen <= 1'b1;
                cnt       <= '0;
              end else if (cnt_inc > i1) begin
                state <= ERR;
                err   <= 1'b1;
                busy  <= 1'b0;
              end
            end else if (fall) begin
              state <= ERR;
              err   <= 1'b1;
              busy  <= 1'b0;
            end else if (cnt_inc >= (i1 >> 1)) begin
              busy <= 1'b0;
              if (pr_ok) begin
                pr       <= PR_W'(pr_calc);
                pr_valid <= 1'b1;
                locked   <= 1'b1;
                state    <= DONE;
              end else begin
                state <= ERR;
                err   <= 1'b1;
              end
            end
          end
          DONE: begin
            state <= DONE;
          end
          ERR: begin
            locked <= 1'b0;
            state  <= ARM;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ef_uart_autobaud.sv
// Scoreboard bench: each sent frame pushes its expected lock/err event; a monitor pops on output pulses.
`timescale 1ns/1ps
module tb_ef_uart_autobaud;

  localparam int CW     = 12;
  localparam int PR_W   = 16;
  localparam int MIN_T8 = 128;
  localparam real CLK_NS = 100.0;

  logic            clk;
  logic            rst_n;
  logic            en;
  logic            rx;
  logic [PR_W-1:0] pr;
  logic            pr_valid;
  logic            locked;
  logic            err;
  logic            busy;

  ef_uart_autobaud #(.CW(CW), .PR_W(PR_W), .MIN_T8(MIN_T8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .rx       (rx),
    .pr       (pr),
    .pr_valid (pr_valid),
    .locked   (locked),
    .err      (err),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  typedef struct {
    bit is_lock;
    int pr;
  } ev_t;

  ev_t q[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int exp_pr(input real bit_ns);
    int t8;
    t8 = $rtoi(8.0 * bit_ns / CLK_NS + 0.5);
    return ((t8 + 32) >> 6) - 1;
  endfunction

  // Output monitor: one line per observed pulse.
  always @(negedge clk) begin
    ev_t e;
    if (pr_valid && err) chk("pulse_excl", 1, 0);
    if (pr_valid || err) begin
      if (q.size() == 0) begin
        chk("spurious_pulse", q.size(), 1);
      end else begin
        e = q.pop_front();
        chk("event_kind", int'(pr_valid), int'(e.is_lock));
        if (pr_valid) chk("pr_value", int'(pr), e.pr);
        $display("[TB] event %s pr=%0d (expected %s pr=%0d)",
                 pr_valid ? "lock" : "err", pr, e.is_lock ? "lock" : "err", e.pr);
      end
    end
  end

  task automatic push_ev(input bit is_lock, input int p);
    ev_t e;
    e.is_lock = is_lock;
    e.pr      = p;
    q.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b, input real bit_ns);
    logic [7:0] d;
    d = b;
    @(negedge clk);
    #10;
    rx = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      #(bit_ns);
    end
    rx = 1'b1;
    #(3.0 * bit_ns);
  endtask

  task automatic wait_drain(input int budget);
    int k;
    k = 0;
    while (q.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("drain", q.size(), 0);
  endtask

  task automatic en_cycle();
    en = 1'b0;
    repeat (3) @(negedge clk);
    en = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  localparam real B115 = 8680.55;
  localparam real B57  = 17361.11;
  localparam real B2M  = 500.0;

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    rx    = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_pr", int'(pr), 0);
    chk("rst_pr_valid", int'(pr_valid), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    en = 1'b1;
    repeat (10) @(negedge clk);

    // 0x55 at 115200 baud
    push_ev(1'b1, exp_pr(B115));
    send_byte(8'h55, B115);
    wait_drain(5000);
    chk("locked_115200", int'(locked), 1);
    chk("busy_after_lock", int'(busy), 0);

    // 0x55 at 57600 baud
    en = 1'b0;
    repeat (3) @(negedge clk);
    chk("locked_after_en_drop", int'(locked), 0);
    chk("pr_hold_en_drop", int'(pr), exp_pr(B115));
    en = 1'b1;
    repeat (10) @(negedge clk);
    push_ev(1'b1, exp_pr(B57));
    send_byte(8'h55, B57);
    wait_drain(5000);
    chk("locked_57600", int'(locked), 1);

    // 0xA5 rejected, then 0x55 locks via automatic retry
    en_cycle();
    push_ev(1'b0, 0);
    send_byte(8'hA5, B115);
    push_ev(1'b1, exp_pr(B115));
    send_byte(8'h55, B115);
    wait_drain(5000);
    chk("locked_retry", int'(locked), 1);

    // Short glitch, then line stuck low past the counter limit
    en_cycle();
    push_ev(1'b0, 0);
    @(negedge clk);
    rx = 1'b0;
    #200;
    rx = 1'b1;
    #1000;
    rx = 1'b0;
    #((2.0 ** CW + 50.0) * CLK_NS);
    rx = 1'b1;
    wait_drain(500);
    chk("locked_after_stuck", int'(locked), 0);
    repeat (20) @(negedge clk);

    // en dropped mid-measurement
    rx = 1'b0;
    #(B115);
    @(negedge clk);
    chk("busy_measure_en", int'(busy), 1);
    en = 1'b0;
    repeat (2) @(negedge clk);
    chk("busy_after_en_drop", int'(busy), 0);
    chk("locked_mid_en_drop", int'(locked), 0);
    chk("pr_hold_mid_en_drop", int'(pr), exp_pr(B115));
    rx = 1'b1;
    repeat (20) @(negedge clk);
    en = 1'b1;
    repeat (10) @(negedge clk);
    push_ev(1'b1, exp_pr(B57));
    send_byte(8'h55, B57);
    wait_drain(5000);
    chk("locked_after_reenable", int'(locked), 1);

    // rst_n pulsed mid-measurement
    en_cycle();
    rx = 1'b0;
    #(B115);
    @(negedge clk);
    chk("busy_measure_rst", int'(busy), 1);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("busy_in_rst", int'(busy), 0);
    chk("locked_in_rst", int'(locked), 0);
    rx = 1'b1;
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    push_ev(1'b1, exp_pr(B115));
    send_byte(8'h55, B115);
    wait_drain(5000);
    chk("locked_after_rst", int'(locked), 1);

    // 2 Mbaud: T8 below minimum
    en_cycle();
    push_ev(1'b0, 0);
    send_byte(8'h55, B2M);
    wait_drain(500);
    chk("pr_hold_fast", int'(pr), exp_pr(B115));
    chk("locked_fast", int'(locked), 0);

    repeat (50) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
